// File: rtl/truth_table_scanner_if.sv
// Control and result bundle between a scan requester and truth_table_scanner.
// The result vector is named tbl because "table" is a reserved word in SystemVerilog.
interface truth_table_scanner_if #(
  parameter int N_IN = 4
);
  logic                   start;
  logic [(1<<N_IN)-1:0]   exp_table;
  logic                   busy;
  logic                   tbl_valid;
  logic                   tbl_ready;
  logic [(1<<N_IN)-1:0]   tbl;
  logic                   mismatch;
  logic [N_IN:0]          fail_cnt;
  logic [N_IN-1:0]        first_fail;

  // Requester side: issues scans and consumes results.
  modport master (
    output start, exp_table, tbl_ready,
    input  busy, tbl_valid, tbl, mismatch, fail_cnt, first_fail
  );

  // Scanner side.
  modport slave (
    input  start, exp_table, tbl_ready,
    output busy, tbl_valid, tbl, mismatch, fail_cnt, first_fail
  );
endinterface

// File: rtl/truth_table_scanner.sv
// Walks every input combination of a combinational device, samples its output
// after SETTLE extra cycles, and reports the captured truth table together with
// the mismatch count and lowest failing index against an expected table.
module truth_table_scanner #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_scanner_if.slave  bus,
  output logic [N_IN-1:0]       stim,
  input  logic                  y_in
);

  localparam int              DEPTH      = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST_IDX   = N_IN'(DEPTH - 1);
  localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   idx_q;
  logic [3:0]        wait_q;
  logic [DEPTH-1:0]  exp_q;
  logic [DEPTH-1:0]  tbl_q;
  logic [N_IN:0]     fail_q;
  logic [N_IN-1:0]   ff_q;
  logic              ff_seen_q;
  logic              accept;
  logic              sample;
  logic              last;

  // The vector index doubles as the stimulus, so stim holds the last index in REPORT.
  assign last = (idx_q == LAST_IDX);

  // Next-state decode plus the accept/sample strobes that steer the datapath.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    sample  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (wait_q == 4'd0) begin
          sample = 1'b1;
          if (last) state_d = REPORT;
        end
      end
      REPORT: begin
        if (bus.tbl_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Scan datapath: settle countdown, table capture and failure bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      wait_q    <= '0;
      exp_q     <= '0;
      tbl_q     <= '0;
      fail_q    <= '0;
      ff_q      <= '0;
      ff_seen_q <= 1'b0;
    end else if (accept) begin
      idx_q     <= '0;
      wait_q    <= SETTLE_CNT;
      exp_q     <= bus.exp_table;
      tbl_q     <= '0;
      fail_q    <= '0;
      ff_q      <= '0;
      ff_seen_q <= 1'b0;
    end else if (state_q == SCAN) begin
      if (!sample) begin
        wait_q <= wait_q - 4'd1;
      end else begin
        tbl_q[idx_q] <= y_in;
        if (y_in != exp_q[idx_q]) begin
          fail_q <= fail_q + (N_IN+1)'(1);
          if (!ff_seen_q) begin
            ff_q      <= idx_q;
            ff_seen_q <= 1'b1;
          end
        end
        if (!last) begin
          idx_q  <= idx_q + N_IN'(1);
          wait_q <= SETTLE_CNT;
        end
      end
    end
  end

  assign stim           = idx_q;
  assign bus.busy       = (state_q == SCAN);
  assign bus.tbl_valid  = (state_q == REPORT);
  assign bus.tbl        = tbl_q;
  assign bus.fail_cnt   = fail_q;
  assign bus.first_fail = ff_q;
  assign bus.mismatch   = (fail_q != '0);

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: two instances (SETTLE=1 and SETTLE=3),
// behavioural DUE models, and a scoreboard of expected results per instance.
module tb_truth_table_scanner;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  truth_table_scanner_if #(.N_IN(N)) bus_a ();
  truth_table_scanner_if #(.N_IN(N)) bus_b ();

  logic [N-1:0] stim_a, stim_b;
  logic         y_a, y_b;
  int           due_mode = 0;

  truth_table_scanner #(.N_IN(N), .SETTLE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .stim(stim_a), .y_in(y_a)
  );

  truth_table_scanner #(.N_IN(N), .SETTLE(3)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .stim(stim_b), .y_in(y_b)
  );

  // DUE models; stim[3] is input A.
  function automatic logic due_fn(input int mode, input logic [3:0] s);
    logic a, b, c, d;
    {a, b, c, d} = s;
    case (mode)
      1:       return (a & ~c & ~d) | (a & b) | (a & c);
      2:       return (~b & ~c & d) | b | (a & d);
      default: return 1'b0;
    endcase
  endfunction

  always_comb y_a = due_fn(due_mode, stim_a);
  assign y_b = 1'b0;

  typedef struct {
    logic [15:0] tbl;
    logic [4:0]  fc;
    logic [3:0]  ff;
    logic        mm;
  } res_t;

  res_t sb_a[$];
  res_t sb_b[$];

  function automatic res_t model(input int mode, input logic [15:0] exp);
    res_t r;
    bit   seen;
    r.tbl = '0;
    r.fc  = '0;
    r.ff  = '0;
    seen  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      r.tbl[i] = due_fn(mode, 4'(i));
      if (r.tbl[i] != exp[i]) begin
        r.fc++;
        if (!seen) begin
          r.ff = 4'(i);
          seen = 1'b1;
        end
      end
    end
    r.mm = (r.fc != 0);
    return r;
  endfunction

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_a(input int mode, input logic [15:0] exp, input bit push);
    due_mode = mode;
    if (push) sb_a.push_back(model(mode, exp));
    @(negedge clk);
    bus_a.exp_table = exp;
    bus_a.start     = 1'b1;
    @(posedge clk);
    #1;
    bus_a.start     = 1'b0;
    bus_a.exp_table = ~exp;   // must not disturb the scan in flight
  endtask

  task automatic wait_valid_a(output int lat);
    lat = 0;
    while (bus_a.tbl_valid !== 1'b1 && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_a(input string tag);
    res_t e;
    chk({tag, "_sb_depth"}, sb_a.size(), 1);
    if (sb_a.size() != 0) begin
      e = sb_a.pop_front();
      chk({tag, "_table"},      bus_a.tbl,        e.tbl);
      chk({tag, "_fail_cnt"},   bus_a.fail_cnt,   e.fc);
      chk({tag, "_first_fail"}, bus_a.first_fail, e.ff);
      chk({tag, "_mismatch"},   bus_a.mismatch,   e.mm);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   bad;
    int   k;
    res_t e;
    logic [15:0] snap_tbl;
    logic [4:0]  snap_fc;
    logic [3:0]  snap_ff;

    bus_a.start = 1'b0; bus_a.exp_table = '0; bus_a.tbl_ready = 1'b1;
    bus_b.start = 1'b0; bus_b.exp_table = '0; bus_b.tbl_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stim",     stim_a,          0);
    chk("rst_busy",     bus_a.busy,      0);
    chk("rst_valid",    bus_a.tbl_valid, 0);
    chk("rst_table",    bus_a.tbl,       0);
    chk("rst_fail_cnt", bus_a.fail_cnt,  0);
    chk("rst_mismatch", bus_a.mismatch,  0);
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: DUE1, matching expected table
    start_a(1, 16'hFD00, 1'b1);
    chk("t1_busy", bus_a.busy, 1);
    wait_valid_a(lat);
    chk("t1_latency",  lat,            32);
    chk("t1_table_k",  bus_a.tbl,      16'hFD00);
    chk("t1_fc_k",     bus_a.fail_cnt, 0);
    chk("t1_stim_rep", stim_a,         15);
    check_a("t1");
    @(posedge clk);
    #1;
    chk("t1_valid_drop", bus_a.tbl_valid, 0);
    chk("t1_table_held", bus_a.tbl,       16'hFD00);

    // Test 2: DUE2 against 0xFAF0
    start_a(2, 16'hFAF0, 1'b1);
    wait_valid_a(lat);
    chk("t2_latency", lat,              32);
    chk("t2_table_k", bus_a.tbl,        16'hFAF2);
    chk("t2_fc_k",    bus_a.fail_cnt,   1);
    chk("t2_ff_k",    bus_a.first_fail, 1);
    chk("t2_mm_k",    bus_a.mismatch,   1);
    check_a("t2");
    @(posedge clk);
    #1;

    // Test 3: DUE2 against all zeros
    start_a(2, 16'h0000, 1'b1);
    wait_valid_a(lat);
    chk("t3_fc_k", bus_a.fail_cnt,   11);
    chk("t3_ff_k", bus_a.first_fail, 1);
    check_a("t3");
    @(posedge clk);
    #1;

    // Test 4: SETTLE=3, y tied low, expecting all ones
    sb_b.push_back(model(0, 16'hFFFF));
    @(negedge clk);
    bus_b.exp_table = 16'hFFFF;
    bus_b.start     = 1'b1;
    @(posedge clk);
    #1;
    bus_b.start = 1'b0;
    lat = 0;
    bad = 0;
    while (bus_b.tbl_valid !== 1'b1 && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
      k = (lat / 4 > 15) ? 15 : lat / 4;
      if (stim_b !== 4'(k)) bad++;
    end
    chk("t4_stim_hold", bad, 0);
    chk("t4_latency",   lat, 64);
    chk("t4_fc_k",      bus_b.fail_cnt,   16);
    chk("t4_ff_k",      bus_b.first_fail, 0);
    chk("t4_table_k",   bus_b.tbl,        0);
    chk("t4_sb_depth",  sb_b.size(),      1);
    if (sb_b.size() != 0) begin
      e = sb_b.pop_front();
      chk("t4_table",    bus_b.tbl,        e.tbl);
      chk("t4_fail_cnt", bus_b.fail_cnt,   e.fc);
      chk("t4_mismatch", bus_b.mismatch,   e.mm);
    end

    // Test 5: backpressure with stray start pulses
    bus_a.tbl_ready = 1'b0;
    start_a(1, 16'hFD00, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus_a.start = 1'b1;
    @(posedge clk);
    #1;
    bus_a.start = 1'b0;
    chk("t5_busy_scan", bus_a.busy, 1);
    wait_valid_a(lat);
    snap_tbl = bus_a.tbl;
    snap_fc  = bus_a.fail_cnt;
    snap_ff  = bus_a.first_fail;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) bus_a.start = 1'b1;
      @(posedge clk);
      #1;
      bus_a.start = 1'b0;
      if (bus_a.tbl_valid !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.tbl !== snap_tbl ||
          bus_a.fail_cnt !== snap_fc || bus_a.first_fail !== snap_ff || stim_a !== 4'hF)
        bad++;
    end
    chk("t5_stable", bad, 0);
    check_a("t5");
    @(negedge clk);
    bus_a.tbl_ready = 1'b1;
    bus_a.start     = 1'b1;   // coincides with the handshake, must be dropped
    @(posedge clk);
    #1;
    bus_a.start = 1'b0;
    chk("t5_valid_drop", bus_a.tbl_valid, 0);
    chk("t5_idle_busy",  bus_a.busy,      0);
    @(posedge clk);
    #1;
    chk("t5_no_restart", bus_a.busy, 0);
    chk("t5_table_held", bus_a.tbl,  16'hFD00);

    // Test 6: asynchronous reset mid-scan at stim=7
    start_a(2, 16'h0000, 1'b0);
    lat = 0;
    while (stim_a !== 4'd7 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("t6_reached_7", stim_a, 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_stim",       stim_a,           0);
    chk("t6_busy",       bus_a.busy,       0);
    chk("t6_valid",      bus_a.tbl_valid,  0);
    chk("t6_table",      bus_a.tbl,        0);
    chk("t6_fail_cnt",   bus_a.fail_cnt,   0);
    chk("t6_first_fail", bus_a.first_fail, 0);
    chk("t6_mismatch",   bus_a.mismatch,   0);
    @(negedge clk);
    rst_n = 1'b1;
    start_a(1, 16'hFD00, 1'b1);
    wait_valid_a(lat);
    chk("t6_latency", lat, 32);
    check_a("t6");
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
